// File: rtl/service_4_alarm.sv
// Alarm-clock service block: arm/ring/game/dismiss FSM, three-round memory game scorer, 4-bit LFSR with one-hot LED.
// Optional macro SERVICE4_INTERNAL_TARGET_EN replaces the random_led target input with an internally latched copy of hot.
module service_4_alarm (
  input  logic        clk,
  input  logic        resetn,
  input  logic        SPDT4,
  input  logic [15:0] current,
  input  logic [15:0] alarm,
  input  logic        push_m,
  input  logic [9:0]  SPDTs,
  input  logic [9:0]  random_led,
  output logic [2:0]  alarm_state,
  output logic        mini_game,
  output logic [15:0] count_state,
  output logic [3:0]  q,
  output logic [9:0]  hot
);

  localparam logic [2:0] S0 = 3'b000;
  localparam logic [2:0] S1 = 3'b001;
  localparam logic [2:0] S2 = 3'b010;
  localparam logic [2:0] S3 = 3'b100;

  localparam logic [15:0] C0 = 16'd0;
  localparam logic [15:0] C3 = 16'd3;

  logic [2:0]  state_reg, state_next;
  logic [15:0] count_reg, count_next;
  logic        mini_reg, mini_next;
  logic [19:0] prev_reg, prev_next;
  logic        was_s2_reg;
  logic [3:0]  q_reg;
  logic [3:0]  q_mod;
  logic [19:0] pair;
  logic [9:0]  target;
  logic        in_s2;
  logic        changed;
  logic        match;
  logic        round_en;

  assign pair  = {SPDTs, random_led};
  assign in_s2 = (state_reg == S2);

`ifdef SERVICE4_INTERNAL_TARGET_EN
  logic [9:0] target_reg;
  assign target  = target_reg;
  assign changed = (SPDTs != prev_reg[19:10]);

  // Target refreshes on game entry and after each scored round so the player chases a new LED.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      target_reg <= 10'd0;
    end else if (in_s2 && (!was_s2_reg || round_en)) begin
      target_reg <= hot;
    end
  end
`else
  assign target  = random_led;
  assign changed = (pair != prev_reg);
`endif

  assign match = (SPDTs == target) && (target != 10'd0);

  // SPDT4 low dominates every other transition.
  always_comb begin
    state_next = state_reg;
    if (!SPDT4) begin
      state_next = S0;
    end else begin
      case (state_reg)
        S0:      if (current == alarm) state_next = S1;
        S1:      if (push_m)           state_next = S2;
        S2:      if (mini_reg)         state_next = S3;
        S3:      state_next = S3;
        default: state_next = S0;
      endcase
    end
  end

  // First S2 cycle only captures the pair; later cycles score whenever it changes.
  always_comb begin
    count_next = count_reg;
    mini_next  = mini_reg;
    prev_next  = prev_reg;
    round_en   = 1'b0;
    if (!in_s2) begin
      count_next = C0;
      mini_next  = 1'b0;
      prev_next  = pair;
    end else if (!was_s2_reg) begin
      prev_next = pair;
    end else if (changed) begin
      round_en  = 1'b1;
      prev_next = pair;
      if (match) begin
        count_next = (count_reg == C3) ? C3 : count_reg + 16'd1;
        if (count_next == C3) mini_next = 1'b1;
      end else begin
        count_next = C0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg  <= S0;
      count_reg  <= C0;
      mini_reg   <= 1'b0;
      prev_reg   <= 20'd0;
      was_s2_reg <= 1'b0;
      q_reg      <= 4'b0001;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      mini_reg   <= mini_next;
      prev_reg   <= prev_next;
      was_s2_reg <= in_s2;
      q_reg      <= {q_reg[2:0], q_reg[3] ^ q_reg[2]};
    end
  end

  assign q_mod = (q_reg >= 4'd10) ? (q_reg - 4'd10) : q_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_hot
      assign hot[gi] = (q_mod == 4'(gi));
    end
  endgenerate

  assign alarm_state = state_reg;
  assign mini_game   = mini_reg;
  assign count_state = count_reg;
  assign q           = q_reg;

endmodule

// File: tb/tb_service_4_alarm.sv
// Self-checking bench for service_4_alarm: directed test-plan steps plus random traffic against a rule-level model.
module tb_service_4_alarm;

  logic        clk = 1'b0;
  logic        resetn;
  logic        SPDT4;
  logic [15:0] current;
  logic [15:0] alarm;
  logic        push_m;
  logic [9:0]  SPDTs;
  logic [9:0]  random_led;
  logic [2:0]  alarm_state;
  logic        mini_game;
  logic [15:0] count_state;
  logic [3:0]  q;
  logic [9:0]  hot;

  service_4_alarm dut (
    .clk(clk), .resetn(resetn), .SPDT4(SPDT4), .current(current), .alarm(alarm),
    .push_m(push_m), .SPDTs(SPDTs), .random_led(random_led),
    .alarm_state(alarm_state), .mini_game(mini_game), .count_state(count_state),
    .q(q), .hot(hot)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Maximal-length sequence of x^4+x^3+1 starting from the reset seed.
  int lfsr_tab [15] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};

  // Model state: alarm mode as spec code, game progress, cycles spent in the game.
  int          m_st;
  int          m_cnt;
  bit          m_won;
  logic [19:0] m_prev;
  int          m_s2_age;
  int          m_idx;
  bit          m_valid = 1'b0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    int nst;
    logic [19:0] pr;
    pr = {SPDTs, random_led};
    if (!resetn) begin
      m_st = 0; m_cnt = 0; m_won = 1'b0; m_prev = 20'd0; m_s2_age = 0; m_idx = 0;
      m_valid = 1'b1;
    end else begin
      nst = m_st;
      if (!SPDT4) nst = 0;
      else if (m_st == 0 && current == alarm) nst = 1;
      else if (m_st == 1 && push_m) nst = 2;
      else if (m_st == 2 && m_won) nst = 4;
      if (m_st == 2) begin
        if (m_s2_age == 0) begin
          m_prev = pr;
        end else if (pr != m_prev) begin
          m_prev = pr;
          if (SPDTs == random_led && random_led != 10'd0) begin
            m_cnt = (m_cnt < 3) ? m_cnt + 1 : 3;
            if (m_cnt == 3) m_won = 1'b1;
          end else begin
            m_cnt = 0;
          end
        end
        m_s2_age++;
      end else begin
        m_cnt = 0; m_won = 1'b0; m_prev = pr; m_s2_age = 0;
      end
      m_st  = nst;
      m_idx = (m_idx + 1) % 15;
    end
  endtask

  task automatic tick();
    int qv;
    @(posedge clk);
    model_update();
    #1;
    if (m_valid) begin
      qv = lfsr_tab[m_idx];
      check("alarm_state", 16'(alarm_state), 16'(m_st));
      check("count_state", count_state, 16'(m_cnt));
      check("mini_game", 16'(mini_game), 16'(m_won));
      check("q", 16'(q), 16'(qv));
      check("hot", 16'(hot), 16'(10'd1 << (qv % 10)));
      check("hot_onehot", 16'($countones(hot)), 16'd1);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic hold_pair(input logic [9:0] sw, input logic [9:0] led, input int n);
    SPDTs = sw; random_led = led;
    ticks(n);
    $display("pair sw=%h led=%h -> state=%b count=%0d won=%b", sw, led, alarm_state, count_state, mini_game);
  endtask

  task automatic reach_game();
    SPDT4 = 1'b1; current = 16'd0; alarm = 16'd7; push_m = 1'b0;
    ticks(2);
    current = 16'd7; tick(); current = 16'd8;
    tick();
    push_m = 1'b1; tick(); push_m = 1'b0;
  endtask

  logic [9:0] sw_tab [9] = '{10'h000, 10'h000, 10'h000, 10'h001, 10'h020, 10'h010, 10'h004, 10'h020, 10'h080};
  logic [9:0] led_tab[9] = '{10'h001, 10'h000, 10'h001, 10'h001, 10'h020, 10'h020, 10'h004, 10'h020, 10'h080};
  int         cnt_tab[9] = '{0, 0, 0, 1, 2, 0, 1, 2, 3};

  initial begin
    resetn = 1'b0; SPDT4 = 1'b0; current = 16'd0; alarm = 16'd0;
    push_m = 1'b0; SPDTs = 10'd0; random_led = 10'd0;
    ticks(2);
    check("reset_state", 16'(alarm_state), 16'd0);
    check("reset_q", 16'(q), 16'd1);
    check("reset_hot", 16'(hot), 16'h002);
    resetn = 1'b1;

    // LFSR free-run: full period returns to the seed.
    ticks(15);
    check("lfsr_period", 16'(q), 16'd1);
    $display("lfsr free-run 15 cycles q=%0d", q);

    // Arm and ramp current past the alarm time.
    SPDT4 = 1'b1; alarm = 16'd10;
    for (int t = 0; t <= 20; t++) begin
      current = 16'(t);
      tick();
      if (t == 10) check("ring_on_match", 16'(alarm_state), 16'h001);
    end
    check("ring_holds", 16'(alarm_state), 16'h001);
    $display("ramp done state=%b", alarm_state);

    push_m = 1'b1; tick(); push_m = 1'b0;
    check("enter_game", 16'(alarm_state), 16'h002);
    check("game_count0", count_state, 16'd0);

    for (int k = 0; k < 9; k++) begin
      hold_pair(sw_tab[k], led_tab[k], (k == 8) ? 1 : 10);
      check("plan_count", count_state, 16'(cnt_tab[k]));
    end
    check("won_flag", 16'(mini_game), 16'd1);
    tick();
    check("dismissed", 16'(alarm_state), 16'h004);
    tick();
    check("dismiss_clear", count_state, 16'd0);
    current = 16'd10; ticks(3);
    check("no_rering", 16'(alarm_state), 16'h004);

    SPDT4 = 1'b0; tick();
    check("disarm", 16'(alarm_state), 16'h000);
    SPDT4 = 1'b1; tick(); tick();
    check("rearm_ring", 16'(alarm_state), 16'h001);
    $display("re-arm state=%b", alarm_state);

    // Reset in the middle of a game.
    SPDTs = 10'd0; random_led = 10'd0; SPDT4 = 1'b0; tick();
    reach_game();
    tick();
    hold_pair(10'h001, 10'h001, 3);
    hold_pair(10'h002, 10'h002, 3);
    check("midgame_count2", count_state, 16'd2);
    resetn = 1'b0; tick(); resetn = 1'b1;
    check("midreset_state", 16'(alarm_state), 16'd0);
    check("midreset_count", count_state, 16'd0);
    check("midreset_won", 16'(mini_game), 16'd0);
    check("midreset_q", 16'(q), 16'd1);
    $display("mid-game reset state=%b count=%0d q=%0d", alarm_state, count_state, q);

    // Random traffic biased toward matches and alarm hits.
    alarm = 16'd3;
    for (int n = 0; n < 1500; n++) begin
      SPDT4   = ($urandom_range(0, 29) != 0);
      current = 16'($urandom_range(0, 5));
      push_m  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) begin
        SPDTs      = ($urandom_range(0, 4) == 0) ? 10'd0 : (10'd1 << $urandom_range(0, 2));
        random_led = ($urandom_range(0, 1) == 0) ? SPDTs : (10'd1 << $urandom_range(0, 2));
      end
      resetn = ($urandom_range(0, 299) != 0);
      tick();
      if (n % 100 == 0)
        $display("random step %0d state=%b count=%0d won=%b q=%0d", n, alarm_state, count_state, mini_game, q);
    end
    resetn = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
